// File: rtl/simon_data_in_bs.sv
// Byte-serial SIMON packet receiver.
// Parses header/count/payload of key and data packets arriving one byte per
// cycle, assembles N-bit words and hands keys and data blocks to the cores
// through four-phase newX/loadX handshakes. Reports framing, type and
// sequence errors as single-cycle pulses.
module simon_data_in_bs #(
    parameter int N   = 16,
    parameter int M   = 4,
    parameter int BPP = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_first,
    output logic             in_ready,
    output logic             newKEY,
    input  logic             loadKEY,
    output logic [M*N-1:0]   KEY,
    output logic             newDATA,
    input  logic             loadDATA,
    output logic [2*N-1:0]   inDATA,
    output logic             modeDEC,
    output logic [7:0]       infoIN,
    output logic [7:0]       countIN,
    output logic             in_donePKT,
    output logic             errPKT,
    output logic [1:0]       errCODE
);

    localparam int KW = M * N;            // key payload bits
    localparam int DW = BPP * 2 * N;      // data payload bits
    localparam int PW = (KW > DW) ? KW : DW;
    localparam logic [5:0] KLAST    = 6'(KW / 8 - 1);
    localparam logic [5:0] DLAST    = 6'(DW / 8 - 1);
    localparam logic [1:0] BLK_LAST = 2'(BPP - 1);

    localparam logic [1:0] T_KEY = 2'b01;

    localparam logic [1:0] E_FRAME = 2'b01;
    localparam logic [1:0] E_TYPE  = 2'b10;
    localparam logic [1:0] E_SEQ   = 2'b11;

    typedef enum logic [2:0] {
        S_HDR, S_CNT, S_PAY, S_KHS, S_DHS, S_SKIP
    } state_t;

    // Handshake sub-phases: raise newX, wait loadX high, drop newX one
    // cycle later, wait loadX low.
    typedef enum logic [1:0] {
        H_SET, H_HI, H_DROP, H_LO
    } hs_t;

    state_t          r_state;
    hs_t             r_hs;
    logic            r_ready;
    logic [5:0]      r_cnt;
    logic [1:0]      r_blk;
    logic [7:0]      r_seq;
    logic [7:0]      r_info;
    logic [7:0]      r_count;
    logic [PW-1:0]   r_pay;
    logic [KW-1:0]   r_key;
    logic [2*N-1:0]  r_indata;
    logic            r_newkey;
    logic            r_newdata;
    logic            r_mode;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_code;

    logic            w_acc;
    logic            w_take_hdr;
    logic            w_last;
    logic [PW-1:0]   w_shift;

    assign w_acc      = in_valid && r_ready;
    // Any accepted byte flagged first starts a new packet, whatever state
    // the parser is in (bytes are never accepted during handshakes).
    assign w_take_hdr = w_acc && in_first;
    assign w_last     = (r_info[7:6] == T_KEY) ? (r_cnt == KLAST) : (r_cnt == DLAST);
    assign w_shift    = {r_pay[PW-9:0], in_byte};

    // Payload buffer: bytes shift in MSB-first; during data handshakes the
    // next block is shifted up into the top block position.
    always_ff @(posedge clk) begin
        if (r_state == S_PAY && w_acc && !in_first)
            r_pay <= w_shift;
        else if (r_state == S_DHS && r_hs == H_SET)
            r_pay <= r_pay << (2 * N);
    end

    // Packet parser FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (R) begin
            r_state   <= S_HDR;
            r_hs      <= H_SET;
            r_ready   <= 1'b0;
            r_cnt     <= '0;
            r_blk     <= '0;
            r_seq     <= '0;
            r_info    <= '0;
            r_count   <= '0;
            r_key     <= '0;
            r_indata  <= '0;
            r_newkey  <= 1'b0;
            r_newdata <= 1'b0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state != S_KHS && r_state != S_DHS)
                r_ready <= 1'b1;

            if (w_take_hdr) begin
                r_info <= in_byte;
                r_cnt  <= '0;
                if (r_state == S_CNT || r_state == S_PAY) begin
                    r_err  <= 1'b1;
                    r_code <= E_FRAME;
                end else if (in_byte[7:6] == 2'b00) begin
                    r_err  <= 1'b1;
                    r_code <= E_TYPE;
                end
                r_state <= (in_byte[7:6] == 2'b00) ? S_SKIP : S_CNT;
            end else begin
                case (r_state)
                    S_CNT: begin
                        if (w_acc) begin
                            r_count <= in_byte;
                            r_cnt   <= '0;
                            if (r_info[7:6] != T_KEY && in_byte != r_seq) begin
                                r_err   <= 1'b1;
                                r_code  <= E_SEQ;
                                r_state <= S_SKIP;
                            end else begin
                                r_state <= S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        if (w_acc) begin
                            r_cnt <= r_cnt + 6'd1;
                            if (w_last) begin
                                r_ready <= 1'b0;
                                r_hs    <= H_SET;
                                r_blk   <= '0;
                                if (r_info[7:6] == T_KEY) begin
                                    r_key   <= w_shift[KW-1:0];
                                    r_state <= S_KHS;
                                end else begin
                                    r_state <= S_DHS;
                                end
                            end
                        end
                    end
                    S_KHS: begin
                        case (r_hs)
                            H_SET: begin
                                r_newkey <= 1'b1;
                                r_hs     <= H_HI;
                            end
                            H_HI: if (loadKEY) r_hs <= H_DROP;
                            H_DROP: begin
                                r_newkey <= 1'b0;
                                r_hs     <= H_LO;
                            end
                            H_LO: begin
                                if (!loadKEY) begin
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                    r_seq   <= '0;
                                    r_state <= S_HDR;
                                end
                            end
                            default: r_hs <= H_SET;
                        endcase
                    end
                    S_DHS: begin
                        case (r_hs)
                            H_SET: begin
                                r_indata  <= r_pay[DW-1 -: 2*N];
                                r_mode    <= r_info[6];
                                r_newdata <= 1'b1;
                                r_hs      <= H_HI;
                            end
                            H_HI: if (loadDATA) r_hs <= H_DROP;
                            H_DROP: begin
                                r_newdata <= 1'b0;
                                r_hs      <= H_LO;
                            end
                            H_LO: begin
                                if (!loadDATA) begin
                                    r_hs <= H_SET;
                                    if (r_blk == BLK_LAST) begin
                                        r_done  <= 1'b1;
                                        r_ready <= 1'b1;
                                        r_seq   <= r_seq + 8'd1;
                                        r_state <= S_HDR;
                                    end else begin
                                        r_blk <= r_blk + 2'd1;
                                    end
                                end
                            end
                            default: r_hs <= H_SET;
                        endcase
                    end
                    default: ;   // HDR and SKIP only react to a first byte
                endcase
            end
        end
    end

    assign in_ready   = r_ready;
    assign newKEY     = r_newkey;
    assign KEY        = r_key;
    assign newDATA    = r_newdata;
    assign inDATA     = r_indata;
    assign modeDEC    = r_mode;
    assign infoIN     = r_info;
    assign countIN    = r_count;
    assign in_donePKT = r_done;
    assign errPKT     = r_err;
    assign errCODE    = r_code;

endmodule
